// File: rtl/memory_feeder_multi.sv
// memory_feeder_multi: on each new bunch crossing, copies one PAGE_DEPTH-word
// page from NCH lockstep master BRAMs into NCH paged working BRAMs.
// The master read pointer walks the master memory one page per batch. The
// working page is selected by the low bits of the batch bx.
module memory_feeder_multi #(
  parameter int NCH          = 2,
  parameter int WIDTH        = 32,
  parameter int MASTER_DEPTH = 64,
  parameter int PAGE_DEPTH   = 32,
  parameter int NPAGES       = 2,
  parameter int RD_LAT       = 2,
  parameter int BX_W         = 3
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         en_proc,
  input  logic [BX_W-1:0]                              bx_in,
  input  logic [NCH-1:0]                               chan_en,
  output logic [$clog2(MASTER_DEPTH)-1:0]              master_addr,
  input  logic [NCH*WIDTH-1:0]                         master_dout,
  output logic [$clog2(NPAGES)+$clog2(PAGE_DEPTH)-1:0] mem_addr,
  output logic [NCH*WIDTH-1:0]                         mem_din,
  output logic [NCH-1:0]                               mem_wea,
  output logic                                         busy,
  output logic                                         done,
  output logic [BX_W-1:0]                              bx_out,
  output logic                                         overrun
);

  localparam int AW  = $clog2(MASTER_DEPTH);
  localparam int PW  = $clog2(PAGE_DEPTH);
  localparam int PGW = $clog2(NPAGES);
  // Every pipe stage except the last: once these are clear, the final write
  // is already on the outputs and the batch can close at this edge.
  localparam logic [RD_LAT-1:0] DRAIN_MASK = {RD_LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              trig, start, issue, batch_end, drain_empty, wr_vld;
  logic              armed, pend;
  logic [BX_W-1:0]   last_bx, pend_bx, batch_bx;
  logic [AW-1:0]     base, base_nxt;
  logic [PW-1:0]     rd_off;
  logic [RD_LAT-1:0] vld_p;
  logic [PW-1:0]     off_p [RD_LAT];

  // A trigger is the first enabled cycle after reset or any change of bx.
  assign trig        = en_proc & (~armed | (bx_in != last_bx));
  assign drain_empty = (vld_p & DRAIN_MASK) == '0;
  assign busy        = (state != IDLE);
  assign base_nxt    = (base == AW'(MASTER_DEPTH - PAGE_DEPTH)) ? '0 : base + AW'(PAGE_DEPTH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    batch_end = 1'b0;
    case (state)
      IDLE: begin
        if (trig || pend) begin
          state_nxt = READ;
          start     = 1'b1;
        end
      end
      READ: begin
        issue = 1'b1;
        if (rd_off == PW'(PAGE_DEPTH - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) begin
          state_nxt = IDLE;
          batch_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Trigger bookkeeping: arm flag, last seen bx, pending request, overrun pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      armed   <= 1'b0;
      last_bx <= '0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (trig) begin
        armed   <= 1'b1;
        last_bx <= bx_in;
      end
      if (start) pend <= 1'b0;
      if (trig && busy) begin
        if (pend) overrun <= 1'b1;
        pend <= 1'b1;
      end
    end
  end

  // Read side: master pointer, page offset counter, base advance
  always_ff @(posedge clk) begin
    if (reset) begin
      master_addr <= '0;
      rd_off      <= '0;
      base        <= '0;
    end else begin
      if (start) begin
        master_addr <= base;
        rd_off      <= '0;
        base        <= base_nxt;
      end else if (issue) begin
        rd_off <= rd_off + PW'(1);
        if (state_nxt == READ) master_addr <= master_addr + AW'(1);
      end
    end
  end

  // Stage p0..p(RD_LAT-1): valid bits follow each issued read through the BRAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p  <= '0;
      done   <= 1'b0;
      bx_out <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      done <= batch_end;
      if (batch_end) bx_out <= batch_bx;
    end
  end

  // Data companions of the valid pipe plus the latched batch/pending bx
  always_ff @(posedge clk) begin
    off_p[0] <= rd_off;
    for (int i = 1; i < RD_LAT; i++) off_p[i] <= off_p[i-1];
    if (start)        batch_bx <= trig ? bx_in : pend_bx;
    if (trig && busy) pend_bx  <= bx_in;
  end

  // Write stage: the oldest pipe entry meets the master read data
  assign wr_vld   = vld_p[RD_LAT-1];
  assign mem_wea  = wr_vld ? chan_en : '0;
  assign mem_addr = wr_vld ? {batch_bx[PGW-1:0], off_p[RD_LAT-1]} : '0;
  assign mem_din  = wr_vld ? master_dout : '0;

endmodule

// File: tb/tb_memory_feeder_multi.sv
// Directed bench for memory_feeder_multi: a default 2-channel instance and a
// 4-channel, 4-page, single-cycle-latency instance, each with a master model.
module tb_memory_feeder_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic         en_a;
  logic [2:0]   bx_a;
  logic [1:0]   ce_a;
  logic [5:0]   a_maddr;
  logic [63:0]  a_mdout;
  logic [5:0]   a_addr;
  logic [63:0]  a_din;
  logic [1:0]   a_wea;
  logic         a_busy, a_done, a_ovr;
  logic [2:0]   a_bxout;

  // Instance B: NCH=4, NPAGES=4, RD_LAT=1
  logic         en_b;
  logic [2:0]   bx_b;
  logic [3:0]   ce_b;
  logic [5:0]   b_maddr;
  logic [127:0] b_mdout;
  logic [6:0]   b_addr;
  logic [127:0] b_din;
  logic [3:0]   b_wea;
  logic         b_busy, b_done, b_ovr;
  logic [2:0]   b_bxout;

  memory_feeder_multi dut_a (
    .clk(clk), .reset(reset), .en_proc(en_a), .bx_in(bx_a), .chan_en(ce_a),
    .master_addr(a_maddr), .master_dout(a_mdout), .mem_addr(a_addr), .mem_din(a_din),
    .mem_wea(a_wea), .busy(a_busy), .done(a_done), .bx_out(a_bxout), .overrun(a_ovr)
  );

  memory_feeder_multi #(.NCH(4), .NPAGES(4), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .en_proc(en_b), .bx_in(bx_b), .chan_en(ce_b),
    .master_addr(b_maddr), .master_dout(b_mdout), .mem_addr(b_addr), .mem_din(b_din),
    .mem_wea(b_wea), .busy(b_busy), .done(b_done), .bx_out(b_bxout), .overrun(b_ovr)
  );

  // Master memories: channel c holds 0x500 + 0x200*c + address
  logic [5:0] a_aq0, a_aq1, b_aq0;
  always @(posedge clk) begin
    a_aq0 <= a_maddr;
    a_aq1 <= a_aq0;
    b_aq0 <= b_maddr;
  end
  assign a_mdout = {32'h700 + 32'(a_aq1), 32'h500 + 32'(a_aq1)};
  assign b_mdout = {32'hB00 + 32'(b_aq0), 32'h900 + 32'(b_aq0),
                    32'h700 + 32'(b_aq0), 32'h500 + 32'(b_aq0)};

  // Observation mux so one checking sequence serves both instances
  bit           sel;
  logic [5:0]   o_maddr;
  logic [6:0]   o_addr;
  logic [127:0] o_din;
  logic [3:0]   o_wea;
  logic         o_busy, o_done, o_ovr;
  logic [2:0]   o_bxout;
  always_comb begin
    o_maddr = a_maddr;
    o_addr  = {1'b0, a_addr};
    o_din   = {64'd0, a_din};
    o_wea   = {2'b00, a_wea};
    o_busy  = a_busy;
    o_done  = a_done;
    o_ovr   = a_ovr;
    o_bxout = a_bxout;
    if (sel) begin
      o_maddr = b_maddr;
      o_addr  = b_addr;
      o_din   = b_din;
      o_wea   = b_wea;
      o_busy  = b_busy;
      o_done  = b_done;
      o_ovr   = b_ovr;
      o_bxout = b_bxout;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bx(input bit s, input logic [2:0] v);
    if (s) bx_b = v;
    else   bx_a = v;
  endtask

  // Inputs for the trigger are already applied; tick n observes cycle T+n.
  task automatic run_batch(input bit s, input int lat, input int nch, input int base,
                           input int page, input int bx, input logic [3:0] ce,
                           input int at1, input int bx1, input int at2, input int bx2,
                           input int ovr_at);
    int done_n;
    int k;
    logic [127:0] ed;
    done_n = 33 + lat;
    for (int n = 1; n <= done_n; n++) begin
      tick();
      if (n <= 32) chk("rd_addr", o_maddr, base + n - 1);
      else         chk("rd_hold", o_maddr, base + 31);
      k = n - 1 - lat;
      if (k >= 0 && k < 32) begin
        ed = '0;
        for (int c = 0; c < nch; c++) ed[c*32 +: 32] = 32'h500 + 32'h200 * c + base + k;
        chk("wr_en", o_wea, ce);
        chk("wr_addr", o_addr, page * 32 + k);
        chk("wr_data", o_din, ed);
      end else begin
        chk("wr_idle", o_wea, 0);
      end
      chk("overrun", o_ovr, n == ovr_at);
      if (n < done_n) begin
        chk("busy", o_busy, 1);
        chk("done_lo", o_done, 0);
      end else begin
        chk("busy_end", o_busy, 0);
        chk("done", o_done, 1);
        chk("bx_out", o_bxout, bx);
      end
      if (n == at1) set_bx(s, bx1[2:0]);
      if (n == at2) set_bx(s, bx2[2:0]);
    end
  endtask

  task automatic idle_chk(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      tick();
      chk("idle_busy", o_busy, 0);
      chk("idle_wea", o_wea, 0);
      chk("idle_done", o_done, 0);
    end
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    en_a = 1'b0; bx_a = 3'd0; ce_a = 2'b11;
    en_b = 1'b0; bx_b = 3'd0; ce_b = 4'b1011;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_maddr", o_maddr, 0);
      chk("rst_wea", o_wea, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_din", o_din, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_bxout", o_bxout, 0);
      chk("rst_ovr", o_ovr, 0);
    end
    sel = 1'b0;
    reset = 1'b0;
    idle_chk(2);

    // First batch after reset, then stepping bx walks base and page
    en_a = 1'b1; bx_a = 3'd2;
    run_batch(0, 2, 2, 0, 0, 2, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);
    bx_a = 3'd3;
    run_batch(0, 2, 2, 32, 1, 3, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);
    bx_a = 3'd4;
    run_batch(0, 2, 2, 0, 0, 4, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);

    // Channel mask: only channel 0 written
    ce_a = 2'b01; bx_a = 3'd5;
    run_batch(0, 2, 2, 32, 1, 5, 4'b0001, 0, 0, 0, 0, 0);
    idle_chk(4);
    ce_a = 2'b11;

    // One trigger while busy becomes a back-to-back pending batch
    bx_a = 3'd6;
    run_batch(0, 2, 2, 0, 0, 6, 4'b0011, 10, 7, 0, 0, 0);
    run_batch(0, 2, 2, 32, 1, 7, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);

    // Two triggers while busy: overrun, only the newest bx runs
    bx_a = 3'd0;
    run_batch(0, 2, 2, 0, 0, 0, 4'b0011, 10, 1, 20, 2, 21);
    run_batch(0, 2, 2, 32, 0, 2, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(6);
    bx_a = 3'd1;
    run_batch(0, 2, 2, 0, 1, 1, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);

    // Reset mid-batch: aborted batch starts at base 32, then nothing is written
    bx_a = 3'd6;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 1) chk("abort_base", o_maddr, 32);
    end
    reset = 1'b1; en_a = 1'b0;
    tick();
    reset = 1'b0;
    chk("post_rst_maddr", o_maddr, 0);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_wea", o_wea, 0);
    chk("post_rst_bxout", o_bxout, 0);
    idle_chk(40);
    en_a = 1'b1;
    run_batch(0, 2, 2, 0, 0, 6, 4'b0011, 0, 0, 0, 0, 0);
    idle_chk(4);

    // Instance B: 4 channels, 4 pages, bx 5 -> page 1, single-cycle latency
    sel = 1'b1;
    #1;
    en_b = 1'b1; bx_b = 3'd5;
    run_batch(1, 1, 4, 0, 1, 5, 4'b1011, 0, 0, 0, 0, 0);
    idle_chk(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/memory_feeder_multi.md
# memory_feeder_multi

Multi-channel, bx-paged successor to the single-channel Feeder. On each new bunch crossing it copies one page of PAGE_DEPTH words from NCH master BRAMs (read in lockstep) into NCH paged working BRAMs. It sits between the master test-vector memories and the processing-block input memories.

## Interface

Parameters:

- NCH, 2: number of channels copied in lockstep.
- WIDTH, 32: data word width.
- MASTER_DEPTH, 64: master memory depth; must be a multiple of PAGE_DEPTH.
- PAGE_DEPTH, 32: words copied per bx; power of 2.
- NPAGES, 2: working-memory pages; power of 2, at least 2.
- RD_LAT, 2: master BRAM read latency in cycles (2 = HIGH_PERFORMANCE).
- BX_W, 3: bx bus width.

Ports:

- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- en_proc  in  1  enables batch starts.
- bx_in  in  BX_W  current bunch crossing.
- chan_en  in  NCH  per-channel write mask.
- master_addr  out  clog2(MASTER_DEPTH)  read address shared by all master memories.
- master_dout  in  NCH*WIDTH  master read data; channel c occupies [c*WIDTH +: WIDTH].
- mem_addr  out  clog2(NPAGES)+clog2(PAGE_DEPTH)  working write address {page, offset}.
- mem_din  out  NCH*WIDTH  write data, same packing as master_dout.
- mem_wea  out  NCH  per-channel write enable.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse after the last write of a batch.
- bx_out  out  BX_W  bx of the last completed batch.
- overrun  out  1  one-cycle pulse when a pending trigger is overwritten.

## Operation

- Trigger: en_proc high and either (a) this is the first en_proc-high cycle since reset (arm flag clear), or (b) bx_in differs from the registered bx of the last trigger.
- The batch bx is latched at the trigger. page = batch_bx[clog2(NPAGES)-1:0].
- Master base pointer: 0 after reset. It advances by PAGE_DEPTH at each batch start, modulo MASTER_DEPTH. The first batch uses base 0.
- States:
  - IDLE: on trigger or pending, go to READ.
  - READ: master_addr = base+k for k = 0..PAGE_DEPTH-1, one per cycle. After k = PAGE_DEPTH-1, go to DRAIN.
  - DRAIN: wait until the RD_LAT-deep valid pipe empties. Then pulse done, update bx_out, go to IDLE.
- Write path: a valid/offset shift register of depth RD_LAT tracks issued reads. When it emerges:
  - mem_wea = chan_en (sampled at write time);
  - mem_addr = {page, k};
  - mem_din = master_dout.
- Triggers while busy:
  - The first one sets pending and stores its bx.
  - A later one while pending is set pulses overrun; the stored bx is replaced by the newest.
- Pending batch: the state goes from IDLE to READ in the cycle after done. The base advances normally.
- en_proc low mid-batch: the batch completes. en_proc gates new triggers only; a pending trigger is still serviced.
- Reset (any cycle, including mid-batch):
  - state IDLE;
  - pipe, pending, arm flag and base cleared;
  - all outputs 0 in the cycle after reset is sampled;
  - no write ever completes from an aborted batch.

## Timing

- Trigger sampled at edge T. busy = 1 from T+1.
- First master_addr at T+1. Last master_addr at T+PAGE_DEPTH.
- First write (mem_wea ≠ 0) at T+1+RD_LAT. Last write at T+PAGE_DEPTH+RD_LAT.
- done and the bx_out update at T+PAGE_DEPTH+RD_LAT+1. busy falls at the same edge.
- With defaults: 32 writes, at T+3 through T+34; done at T+35.
- Back-to-back (pending) batch: next first read at done+1. No write gaps other than the drain.
- master_addr holds its last value while IDLE/DRAIN. mem_wea = 0 whenever no valid word emerges.

## Test plan

- Defaults; master ch0[i] = 0x500+i, ch1[i] = 0x700+i; reset released, en_proc = 1, bx_in = 2 → master_addr 0..31; writes at mem_addr 0..31 with data {0x700+i, 0x500+i}; mem_wea = 2'b11; done at T+35; bx_out = 2.
- bx_in steps 2→3→4 every 40 cycles → batch 2 reads master 32..63 and writes mem_addr 32..63 (page 1); batch 3 wraps to master 0..31 and writes mem_addr 0..31.
- bx changes at T+10 (to 3) → pending; next batch's first read at T+36; bx_out = 3 at its done. Changes at T+10 and T+20 (to 4) → overrun pulse at T+21; only bx 4 is processed.
- chan_en = 2'b01 → mem_wea = 2'b01 on all 32 writes; ch1 working memory unchanged.
- reset asserted at T+15 for one cycle → from T+16: mem_wea = 0, busy = 0, done never pulses; next trigger reads from master base 0.
- RD_LAT = 1, NCH = 4, NPAGES = 4, bx_in = 5 → writes at T+2..T+33 to page 1 (mem_addr 32..63); done at T+34.
